// File: rtl/periferico_bin2bcd_pkg.sv
// -----------------------------------------------------------------------------
// periferico_bin2bcd_pkg
// Shared definitions for the binary-to-BCD peripheral: bus register
// addresses, conversion state encoding and STATUS register bit positions.
// -----------------------------------------------------------------------------
package periferico_bin2bcd_pkg;

    // Register map (5-bit bus address space)
    localparam logic [4:0] ADDR_BIN    = 5'h04;
    localparam logic [4:0] ADDR_CTRL   = 5'h0C;
    localparam logic [4:0] ADDR_BCD_LO = 5'h10;
    localparam logic [4:0] ADDR_BCD_HI = 5'h14;
    localparam logic [4:0] ADDR_STATUS = 5'h18;

    // STATUS register bit positions
    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_BUSY_BIT = 1;

    // CTRL register bit positions
    localparam int CTRL_START_BIT = 0;

    // Conversion engine states
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage : periferico_bin2bcd_pkg

// File: rtl/periferico_bin2bcd_core.sv
// -----------------------------------------------------------------------------
// periferico_bin2bcd_core
// One double-dabble iteration, purely combinational: every BCD digit that is
// 5 or more gets 3 added, then the whole {bcd, bin} register shifts left by 1.
//
// Ports:
//   shreg_in  [4*DIGITS+WIDTH-1:0]  current {bcd digits, binary} register
//   shreg_out [4*DIGITS+WIDTH-1:0]  register after adjust + shift
// -----------------------------------------------------------------------------
module periferico_bin2bcd_core #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic [4*DIGITS+WIDTH-1:0] shreg_in,
    output logic [4*DIGITS+WIDTH-1:0] shreg_out
);

    logic [4*DIGITS+WIDTH-1:0] adj;

    always_comb begin
        // NOTE: every always_comb output gets a full default first, so no path
        // through the block can leave it unassigned and infer a latch.
        adj = shreg_in;
        for (int i = 0; i < DIGITS; i++) begin
            if (adj[WIDTH+4*i +: 4] >= 4'd5) begin
                adj[WIDTH+4*i +: 4] = adj[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        // The top bit of the adjusted value is shifted out; for a valid
        // DIGITS/WIDTH pairing it is always zero.
        shreg_out = adj << 1;
    end

endmodule : periferico_bin2bcd_core

// File: rtl/periferico_bin2bcd.sv
// -----------------------------------------------------------------------------
// periferico_bin2bcd
// Memory-mapped peripheral converting a WIDTH-bit unsigned value into DIGITS
// packed BCD digits with a sequential double-dabble engine (one shift/cycle).
//
// Ports:
//   CLK    system clock, all state changes on the rising edge
//   reset  synchronous active-low reset
//   cs     chip select
//   rd     read strobe  (qualified by cs)
//   wr     write strobe (qualified by cs)
//   addr   [4:0]  register address
//   d_in   [15:0] write data
//   d_out  [15:0] registered read data, valid the cycle after the read edge
// -----------------------------------------------------------------------------
module periferico_bin2bcd
    import periferico_bin2bcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [4:0]  addr,
    input  logic [15:0] d_in,
    output logic [15:0] d_out
);

    localparam int SHW   = 4*DIGITS + WIDTH;
    localparam int BCDW  = 4*DIGITS;
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t             state, state_next;
    logic [WIDTH-1:0]   bin_reg;
    logic [SHW-1:0]     shreg;
    logic [SHW-1:0]     shreg_step;
    logic [CNT_W-1:0]   count;
    logic [BCDW-1:0]    result;
    logic [15:0]        rd_data;

    logic busy, done;
    logic wr_en, rd_en;
    logic bin_wr, start;
    logic last_shift;

    // Bus decode. BIN writes and start requests are both locked out while a
    // conversion is running.
    assign wr_en      = cs & wr;
    assign rd_en      = cs & rd;
    assign bin_wr     = wr_en && (addr == ADDR_BIN) && !busy;
    assign start      = wr_en && (addr == ADDR_CTRL) && d_in[CTRL_START_BIT] && !busy;
    assign last_shift = (state == S_CONV) && (count == LAST_CNT);

    periferico_bin2bcd_core #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_core (
        .shreg_in  (shreg),
        .shreg_out (shreg_step)
    );

    // State register
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and status outputs
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_next = S_CONV;
            end
            S_CONV: begin
                busy = 1'b1;
                if (last_shift) state_next = S_DONE;
            end
            S_DONE: begin
                done = 1'b1;
                // start and BIN write use different addresses, so at most
                // one of them fires in a given cycle.
                if (start)       state_next = S_CONV;
                else if (bin_wr) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Read mux: reflects register contents before any same-edge write.
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_BIN:    rd_data = 16'(bin_reg);
            ADDR_BCD_LO: rd_data = result[15:0];
            ADDR_BCD_HI: rd_data = 16'(result[BCDW-1:16]);
            ADDR_STATUS: begin
                rd_data[STATUS_DONE_BIT] = done;
                rd_data[STATUS_BUSY_BIT] = busy;
            end
            default:     rd_data = '0;
        endcase
    end

    // Datapath registers
    always_ff @(posedge CLK) begin
        // NOTE: the working shift register is reset along with the visible
        // state so an aborted conversion cannot leak a partial result.
        if (!reset) begin
            bin_reg <= '0;
            shreg   <= '0;
            count   <= '0;
            result  <= '0;
            d_out   <= '0;
        end else begin
            if (bin_wr) begin
                bin_reg <= d_in[WIDTH-1:0];
            end

            if (start) begin
                shreg <= {{BCDW{1'b0}}, bin_reg};
                count <= '0;
            end else if (state == S_CONV) begin
                shreg <= shreg_step;
                count <= count + 1'b1;
            end

            // Result only moves on the final shift; earlier results stay
            // readable for the whole conversion.
            if (last_shift) begin
                result <= shreg_step[SHW-1 -: BCDW];
            end

            if (rd_en) begin
                d_out <= rd_data;
            end
        end
    end

endmodule : periferico_bin2bcd

// File: tb/tb_periferico_bin2bcd.sv
// -----------------------------------------------------------------------------
// tb_periferico_bin2bcd
// Self-checking bench for periferico_bin2bcd. Expected BCD values come from a
// decimal-digit model (repeated divide by ten) inside the bench.
// -----------------------------------------------------------------------------
module tb_periferico_bin2bcd;

    localparam logic [4:0] A_BIN    = 5'h04;
    localparam logic [4:0] A_CTRL   = 5'h0C;
    localparam logic [4:0] A_BCD_LO = 5'h10;
    localparam logic [4:0] A_BCD_HI = 5'h14;
    localparam logic [4:0] A_STATUS = 5'h18;

    localparam logic [15:0] ST_IDLE = 16'h0000;
    localparam logic [15:0] ST_DONE = 16'h0001;
    localparam logic [15:0] ST_BUSY = 16'h0002;

    logic        CLK   = 1'b0;
    logic        reset = 1'b0;
    logic        cs    = 1'b0;
    logic        rd    = 1'b0;
    logic        wr    = 1'b0;
    logic [4:0]  addr  = '0;
    logic [15:0] d_in  = '0;
    logic [15:0] d_out;

    int total_cnt = 0;
    int pass_cnt  = 0;

    periferico_bin2bcd dut (
        .CLK   (CLK),
        .reset (reset),
        .cs    (cs),
        .rd    (rd),
        .wr    (wr),
        .addr  (addr),
        .d_in  (d_in),
        .d_out (d_out)
    );

    always #5 CLK = ~CLK;

    // Reference model: five decimal digits by plain arithmetic.
    function automatic logic [19:0] ref_bcd(input int unsigned value);
        logic [19:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    // Bus helpers: called at a falling edge, consume exactly one rising edge,
    // return at the following falling edge with strobes released.
    task automatic bus_write(input logic [4:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
        @(posedge CLK);
        @(negedge CLK);
        cs = 1'b0; wr = 1'b0;
    endtask

    task automatic bus_read(input logic [4:0] a, output logic [15:0] d);
        cs = 1'b1; rd = 1'b1; wr = 1'b0; addr = a;
        @(posedge CLK);
        @(negedge CLK);
        cs = 1'b0; rd = 1'b0;
        d = d_out;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Polls STATUS right after a start: counts BUSY reads until DONE shows up
    // (bounded so a stuck engine cannot hang the run).
    task automatic measure_conv(output int busy_reads, output bit done_seen);
        logic [15:0] s;
        busy_reads = 0;
        done_seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus_read(A_STATUS, s);
            if (s === ST_BUSY) begin
                busy_reads++;
            end else begin
                if (s === ST_DONE) done_seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic convert_and_check(input logic [15:0] value, input string tag,
                                     input bit check_latency);
        logic [19:0] exp;
        logic [15:0] lo, hi;
        int busy_reads;
        bit done_seen;
        exp = ref_bcd(int'(value));
        bus_write(A_BIN, value);
        bus_write(A_CTRL, 16'h0001);
        measure_conv(busy_reads, done_seen);
        total_cnt++;
        if (!done_seen) $display("FAIL %s done: not seen after %0d busy reads", tag, busy_reads);
        else pass_cnt++;
        if (check_latency) begin
            total_cnt++;
            if (busy_reads != 16) $display("FAIL %s latency: got %0d busy cycles, want 16", tag, busy_reads);
            else pass_cnt++;
        end
        bus_read(A_BCD_LO, lo);
        total_cnt++;
        if (lo !== exp[15:0]) $display("FAIL %s bcd_lo: got %h want %h", tag, lo, exp[15:0]);
        else pass_cnt++;
        bus_read(A_BCD_HI, hi);
        total_cnt++;
        if (hi !== {12'h000, exp[19:16]}) $display("FAIL %s bcd_hi: got %h want %h", tag, hi, {12'h000, exp[19:16]});
        else pass_cnt++;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b0;
        repeat (3) @(negedge CLK);
        reset = 1'b1;
        total_cnt++;
        if (d_out !== 16'h0000) $display("FAIL reset d_out: got %h want 0000", d_out);
        else pass_cnt++;
        bus_read(A_STATUS, v);
        total_cnt++;
        if (v !== ST_IDLE) $display("FAIL reset status: got %h want %h", v, ST_IDLE);
        else pass_cnt++;
        bus_read(A_BIN, v);
        total_cnt++;
        if (v !== 16'h0000) $display("FAIL reset bin: got %h want 0000", v);
        else pass_cnt++;
        bus_read(A_BCD_LO, v);
        total_cnt++;
        if (v !== 16'h0000) $display("FAIL reset bcd_lo: got %h want 0000", v);
        else pass_cnt++;
    endtask

    task automatic test_basic();
        convert_and_check(16'd180, "conv_180", 1'b1);
    endtask

    task automatic test_boundaries();
        convert_and_check(16'd65535, "conv_max", 1'b1);
        convert_and_check(16'd0, "conv_zero", 1'b1);
    endtask

    task automatic test_busy_ignore();
        logic [15:0] v;
        int busy_reads;
        bit done_seen;
        bus_write(A_BIN, 16'd9999);
        bus_write(A_CTRL, 16'h0001);
        idle(4);
        bus_write(A_BIN, 16'd1234);
        bus_write(A_CTRL, 16'h0001);
        bus_read(A_BCD_LO, v);
        total_cnt++;
        if (v !== 16'h0000) $display("FAIL busy result_hold: got %h want 0000", v);
        else pass_cnt++;
        measure_conv(busy_reads, done_seen);
        total_cnt++;
        if (!done_seen) $display("FAIL busy done: not seen after %0d busy reads", busy_reads);
        else pass_cnt++;
        bus_read(A_BCD_LO, v);
        total_cnt++;
        if (v !== ref_bcd(9999)) $display("FAIL busy bcd_lo: got %h want %h", v, ref_bcd(9999));
        else pass_cnt++;
        bus_read(A_BIN, v);
        total_cnt++;
        if (v !== 16'd9999) $display("FAIL busy bin_ignored: got %0d want 9999", v);
        else pass_cnt++;
        bus_write(A_BIN, 16'd1234);
        bus_read(A_STATUS, v);
        total_cnt++;
        if (v !== ST_IDLE) $display("FAIL bin_write clears done: got %h want %h", v, ST_IDLE);
        else pass_cnt++;
        bus_write(A_CTRL, 16'h0000);
        bus_read(A_STATUS, v);
        total_cnt++;
        if (v !== ST_IDLE) $display("FAIL ctrl_zero no_start: got %h want %h", v, ST_IDLE);
        else pass_cnt++;
        bus_write(A_CTRL, 16'h0001);
        measure_conv(busy_reads, done_seen);
        bus_read(A_BCD_LO, v);
        total_cnt++;
        if (!done_seen || v !== 16'h1234) $display("FAIL restart bcd_lo: got %h done=%0d want 1234", v, done_seen);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] v;
        bus_write(A_BIN, 16'd4321);
        bus_write(A_CTRL, 16'h0001);
        idle(7);
        // Reset with a concurrent STATUS read: reset must win.
        reset = 1'b0; cs = 1'b1; rd = 1'b1; addr = A_STATUS;
        @(posedge CLK);
        @(negedge CLK);
        reset = 1'b1; cs = 1'b0; rd = 1'b0;
        total_cnt++;
        if (d_out !== 16'h0000) $display("FAIL midreset d_out: got %h want 0000", d_out);
        else pass_cnt++;
        bus_read(A_STATUS, v);
        total_cnt++;
        if (v !== ST_IDLE) $display("FAIL midreset status: got %h want %h", v, ST_IDLE);
        else pass_cnt++;
        idle(20);
        bus_read(A_BCD_LO, v);
        total_cnt++;
        if (v !== 16'h0000) $display("FAIL midreset bcd_lo: got %h want 0000", v);
        else pass_cnt++;
        convert_and_check(16'd4321, "after_reset", 1'b1);
    endtask

    task automatic test_reads();
        logic [15:0] v;
        logic [4:0]  unmapped [4];
        unmapped[0] = 5'h00; unmapped[1] = 5'h08; unmapped[2] = 5'h1C; unmapped[3] = A_CTRL;
        bus_write(A_BIN, 16'hABCD);
        for (int i = 0; i < 4; i++) begin
            bus_read(A_BIN, v);  // preload nonzero so a zero read is meaningful
            bus_read(unmapped[i], v);
            total_cnt++;
            if (v !== 16'h0000) $display("FAIL unmapped read %h: got %h want 0000", unmapped[i], v);
            else pass_cnt++;
        end
        bus_read(A_BIN, v);
        total_cnt++;
        if (v !== 16'hABCD) $display("FAIL bin readback: got %h want abcd", v);
        else pass_cnt++;
        idle(3);
        total_cnt++;
        if (d_out !== 16'hABCD) $display("FAIL d_out hold: got %h want abcd", d_out);
        else pass_cnt++;
        convert_and_check(16'hABCD, "conv_abcd", 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus_read(A_STATUS, v);
            total_cnt++;
            if (v !== ST_DONE) $display("FAIL status sticky read %0d: got %h want %h", i, v, ST_DONE);
            else pass_cnt++;
        end
    endtask

    task automatic test_rd_wr_same_edge();
        logic [15:0] v;
        cs = 1'b1; rd = 1'b1; wr = 1'b1; addr = A_BIN; d_in = 16'h1111;
        @(posedge CLK);
        @(negedge CLK);
        cs = 1'b0; rd = 1'b0; wr = 1'b0;
        total_cnt++;
        if (d_out !== 16'hABCD) $display("FAIL rdwr pre_write data: got %h want abcd", d_out);
        else pass_cnt++;
        bus_read(A_BIN, v);
        total_cnt++;
        if (v !== 16'h1111) $display("FAIL rdwr new bin: got %h want 1111", v);
        else pass_cnt++;
        bus_read(A_STATUS, v);
        total_cnt++;
        if (v !== ST_IDLE) $display("FAIL rdwr status: got %h want %h", v, ST_IDLE);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        int busy_reads;
        bit done_seen;
        convert_and_check(16'd100, "b2b_first", 1'b1);
        bus_write(A_CTRL, 16'h0001);
        bus_read(A_STATUS, v);
        total_cnt++;
        if (v !== ST_BUSY) $display("FAIL b2b done_drop: got %h want %h", v, ST_BUSY);
        else pass_cnt++;
        measure_conv(busy_reads, done_seen);
        total_cnt++;
        if (!done_seen || busy_reads != 15) $display("FAIL b2b latency: got %0d busy cycles done=%0d want 16", busy_reads + 1, done_seen);
        else pass_cnt++;
        bus_read(A_BCD_LO, v);
        total_cnt++;
        if (v !== 16'h0100) $display("FAIL b2b bcd_lo: got %h want 0100", v);
        else pass_cnt++;
        // Old result must stay visible through a whole new conversion.
        bus_write(A_BIN, 16'd7777);
        bus_write(A_CTRL, 16'h0001);
        idle(6);
        bus_read(A_BCD_LO, v);
        total_cnt++;
        if (v !== 16'h0100) $display("FAIL b2b result_hold: got %h want 0100", v);
        else pass_cnt++;
        measure_conv(busy_reads, done_seen);
        bus_read(A_BCD_LO, v);
        total_cnt++;
        if (!done_seen || v !== 16'h7777) $display("FAIL b2b second: got %h done=%0d want 7777", v, done_seen);
        else pass_cnt++;
    endtask

    task automatic test_random();
        logic [15:0] value;
        for (int i = 0; i < 10; i++) begin
            value = 16'($urandom_range(0, 65535));
            convert_and_check(value, $sformatf("rand_%0d_%0d", i, value), 1'b1);
        end
    endtask

    initial begin
        @(negedge CLK);
        test_reset();
        test_basic();
        test_boundaries();
        test_busy_ignore();
        test_reset_mid();
        test_reads();
        test_rd_wr_same_edge();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: timeout reached, passed %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "timeout");
    end

endmodule : tb_periferico_bin2bcd
